hd44780_ctrl: RTL and testbench
===============================

// Module: hd44780_ctrl
// PURPOSE
//  Parametrised HD44780 character-LCD controller for 4- or 8-bit bus, 1/2/4 lines, any column count.
//  Runs the datasheet power-on init, then on trg refreshes the whole display from an external
//  row-major char RAM. Accepts single raw commands via valid/ready. Sits between app logic / frame RAM and LCD pins.
// PARAMETERS
//  CLK_HZ      250_000  input clock frequency, Hz
//  BUS_WIDTH   8        LCD data bus width; legal 4 or 8
//  LINES       4        display lines; legal 1, 2, 4
//  COLS        20       characters per line
//  POWERON_US  100_000  wait after reset release before first write
//  CMD_US      80       busy wait after normal command/data write
//  CLEAR_US    2_000    busy wait after clear (0x01) / return-home (0x02, 0x03)
//  SETUP_CYC   1        rs/db stable cycles before e rises (also hold after e falls)
//  E_CYC       2        e high cycles per pulse
// PORTS
//  clk        in   1                  clock
//  rst        in   1                  asynchronous, active-low reset
//  trg        in   1                  1-cycle pulse: request full display refresh
//  cmd_valid  in   1                  raw command request (rs=0)
//  cmd_data   in   8                  raw command byte
//  cmd_ready  out  1                  command accepted when cmd_valid & cmd_ready
//  busy       out  1                  init, refresh or command in progress
//  init_done  out  1                  power-on init complete; sticky until reset
//  mem_addr   out  clog2(LINES*COLS)  char RAM read address
//  mem_data   in   8                  char RAM data, valid 1 cycle after mem_addr (sync read)
//  e, rs      out  1                  LCD enable, register select
//  db         out  BUS_WIDTH          LCD data; in 4-bit mode maps to DB7..DB4
// BEHAVIOUR
//  Reset: e=0 rs=0 db=0 mem_addr=0 cmd_ready=0 init_done=0 busy=1; FSM->S_PWR; pending-trg cleared.
//  Reset mid-operation aborts any write immediately; init restarts from S_PWR.
//  Cycle conversion: US2CYC(t) = max(1, ceil(t*CLK_HZ/1e6)), evaluated at elaboration.
//  Byte write (bus writer): drive rs/db, SETUP_CYC, e=1 for E_CYC, e=0, hold SETUP_CYC, then wait
//   CLEAR_US if rs=0 & byte in {01,02,03}, else CMD_US. 4-bit mode: high nibble pulse, then low nibble
//   pulse (each full setup/pulse/hold); delay follows the low nibble only. db=0 whenever idle.
//  FSM: S_PWR -> S_INIT -> S_IDLE; S_IDLE -> S_CMD | S_ADDR; S_ADDR -> S_FETCH -> S_CHAR
//   (loop COLS) -> S_ADDR next line | S_IDLE.
//  S_PWR: wait US2CYC(POWERON_US), no e activity.
//  S_INIT 8-bit: 0x30,0x30,0x30 (waits CLEAR_US,CMD_US,CMD_US), then FSET,0x08,0x01,0x06,0x0C.
//   4-bit: single-nibble pulses 0x3,0x3,0x3,0x2 (same waits), then full-byte FSET,0x08,0x01,0x06,0x0C.
//   FSET = 0x20 | (BUS_WIDTH==8)<<4 | (LINES>1)<<3. End: init_done=1.
//  S_IDLE: busy=0, cmd_ready=1. cmd wins over pending trg when both present in same cycle.
//  S_CMD: write cmd_data rs=0 with its delay, back to S_IDLE.
//  Refresh, line L = 0..LINES-1: S_ADDR writes 0x80|base(L); base = {0x00,0x40,COLS,0x40+COLS}[L].
//   S_FETCH drives mem_addr = L*COLS+c, waits 1 cycle; S_CHAR writes mem_data with rs=1. c = 0..COLS-1.
//  trg while busy (init/refresh/cmd) sets pending flag; pending serviced from S_IDLE. Multiple
//   trg while pending collapse to one refresh. trg in S_IDLE starts refresh next cycle.
//  cmd_ready=0 in all states except S_IDLE; cmd_valid elsewhere is held off, never dropped by DUT.
//  mem_addr holds last value outside S_FETCH; no wrap past LINES*COLS-1.
// STRUCTURE
//  Package hd44780_pkg: instruction opcodes (CLEAR, HOME, ENTRY, DISPCTL, FSET, SET_DDRAM),
//   line base table, US2CYC function, FSM state enum.
//  Sub-module hd44780_bus_writer: wr_valid/wr_ready, wr_byte, wr_rs, wr_nibble_only; owns
//   e/rs/db, nibble split, setup/pulse/hold and post-write delay counter (sized for CLEAR/POWERON).
//  Top: FSM, line/col counters, pending-trg flag, power-on counter.
// TESTING
//  8-bit defaults, release rst: no e for 25_000 cycles; pulses 30,30,30,38,08,01,06,0C rs=0; init_done=1.
//  BUS_WIDTH=4: init nibbles 3,3,3,2, then 28 as 2 then 8; char 0x41 rs=1 -> db 4 then 1, 2 e pulses.
//  Refresh 4x20, RAM[i]=i: 0x80,0..19,0xC0,20..39,0x94,40..59,0xD4,60..79; 84 pulses; busy falls.
//  cmd 0x01 in IDLE -> one pulse rs=0, next e rise >= 500 cycles later; cmd held during refresh.
//  3 trg pulses during refresh -> exactly one extra refresh; rst low mid-char -> e=0 db=0 at once, re-init.

Source files
------------

// File: rtl/hd44780_pkg.sv
// Shared definitions for the HD44780 character-LCD controller: opcodes,
// DDRAM line base table, microsecond-to-cycle conversion and FSM states.
package hd44780_pkg;

   localparam logic [7:0] OP_CLEAR     = 8'h01;
   localparam logic [7:0] OP_HOME      = 8'h02;
   localparam logic [7:0] OP_ENTRY     = 8'h06;
   localparam logic [7:0] OP_DISPOFF   = 8'h08;
   localparam logic [7:0] OP_DISPCTL   = 8'h0C;
   localparam logic [7:0] OP_FSET      = 8'h20;
   localparam logic [7:0] OP_WAKE      = 8'h30;
   localparam logic [7:0] OP_SET_DDRAM = 8'h80;

   typedef enum logic [2:0] {
      S_PWR,
      S_INIT,
      S_IDLE,
      S_CMD,
      S_ADDR,
      S_FETCH,
      S_CHAR
   } ctrl_state_t;

   typedef enum logic [2:0] {
      W_IDLE,
      W_SETUP,
      W_PULSE,
      W_HOLD,
      W_DELAY
   } wr_state_t;

   // Round a time in microseconds up to whole clock cycles, never below one.
   function automatic int us2cyc(input longint t_us, input longint clk_hz);
      longint c;
      c = (t_us * clk_hz + longint'(999_999)) / longint'(1_000_000);
      return (c < 1) ? 1 : int'(c);
   endfunction

   // DDRAM start address of each display line; lines 2/3 continue lines 0/1.
   function automatic logic [7:0] line_base(input logic [1:0] line_idx, input int cols);
      case (line_idx)
         2'd0:    return 8'h00;
         2'd1:    return 8'h40;
         2'd2:    return 8'(cols);
         default: return 8'(8'h40 + cols);
      endcase
   endfunction

   // Function-set byte: DL bit for 8-bit bus, N bit for multi-line displays.
   function automatic logic [7:0] fset_byte(input int bus_width, input int lines);
      return OP_FSET | ((bus_width == 8) ? 8'h10 : 8'h00) | ((lines > 1) ? 8'h08 : 8'h00);
   endfunction

   // Power-on init sequence; step 3 (switch to 4-bit) is only used on a 4-bit bus.
   function automatic logic [7:0] init_byte(input logic [3:0] step, input logic [7:0] fset);
      case (step)
         4'd0, 4'd1, 4'd2: return OP_WAKE;
         4'd3:             return OP_FSET;
         4'd4:             return fset;
         4'd5:             return OP_DISPOFF;
         4'd6:             return OP_CLEAR;
         4'd7:             return OP_ENTRY;
         default:          return OP_DISPCTL;
      endcase
   endfunction

endpackage

// File: rtl/hd44780_if.sv
// Host-side bundle of the LCD controller: trigger/command handshake, status,
// frame RAM read port and the LCD pins.
interface hd44780_if #(
   parameter int BUS_WIDTH = 8,
   parameter int ADDR_W    = 7
);
   logic                 trg;
   logic                 cmd_valid;
   logic [7:0]           cmd_data;
   logic                 cmd_ready;
   logic                 busy;
   logic                 init_done;
   logic [ADDR_W-1:0]    mem_addr;
   logic [7:0]           mem_data;
   logic                 e;
   logic                 rs;
   logic [BUS_WIDTH-1:0] db;

   modport master (
      output trg, cmd_valid, cmd_data, mem_data,
      input  cmd_ready, busy, init_done, mem_addr, e, rs, db
   );

   modport slave (
      input  trg, cmd_valid, cmd_data, mem_data,
      output cmd_ready, busy, init_done, mem_addr, e, rs, db
   );
endinterface

// File: rtl/hd44780_bus_writer.sv
// Drives one byte (or a single high nibble) onto the LCD pins with setup,
// enable pulse and hold, then waits out the LCD execution time.
module hd44780_bus_writer
   import hd44780_pkg::*;
#(
   parameter int CLK_HZ    = 250_000,
   parameter int BUS_WIDTH = 8,
   parameter int CMD_US    = 80,
   parameter int CLEAR_US  = 2_000,
   parameter int SETUP_CYC = 1,
   parameter int E_CYC     = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 wr_valid,
   output logic                 wr_ready,
   input  logic [7:0]           wr_byte,
   input  logic                 wr_rs,
   input  logic                 wr_nibble_only,
   input  logic                 wr_long,
   output logic                 e,
   output logic                 rs,
   output logic [BUS_WIDTH-1:0] db
);

   localparam int SETUP_N = (SETUP_CYC < 1) ? 1 : SETUP_CYC;
   localparam int E_N     = (E_CYC < 1) ? 1 : E_CYC;
   localparam int CMD_N   = us2cyc(CMD_US, CLK_HZ);
   localparam int CLEAR_N = us2cyc(CLEAR_US, CLK_HZ);
   localparam int MAX_A   = (CMD_N > CLEAR_N) ? CMD_N : CLEAR_N;
   localparam int MAX_B   = (SETUP_N > E_N) ? SETUP_N : E_N;
   localparam int MAX_N   = (MAX_A > MAX_B) ? MAX_A : MAX_B;
   localparam int CNT_W   = $clog2(MAX_N + 1);

   localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_N - 1);
   localparam logic [CNT_W-1:0] E_LD     = CNT_W'(E_N - 1);
   localparam logic [CNT_W-1:0] CMD_LD   = CNT_W'(CMD_N - 1);
   localparam logic [CNT_W-1:0] CLEAR_LD = CNT_W'(CLEAR_N - 1);

   wr_state_t            state, state_n;
   logic [CNT_W-1:0]     cnt, cnt_n;
   logic [7:0]           byte_q, byte_n;
   logic                 sel_q, sel_n;
   logic                 hi_q, hi_n;
   logic                 two_q, two_n;
   logic                 long_q, long_n;
   logic [BUS_WIDTH-1:0] db_n;

   // Writer state, phase counter and the latched byte being sent.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= W_IDLE;
         cnt    <= '0;
         byte_q <= '0;
         sel_q  <= 1'b0;
         hi_q   <= 1'b0;
         two_q  <= 1'b0;
         long_q <= 1'b0;
      end else begin
         state  <= state_n;
         cnt    <= cnt_n;
         byte_q <= byte_n;
         sel_q  <= sel_n;
         hi_q   <= hi_n;
         two_q  <= two_n;
         long_q <= long_n;
      end
   end

   // Sequence setup -> pulse -> hold (twice for a full byte on a 4-bit bus) -> delay.
   always_comb begin
      state_n  = state;
      cnt_n    = cnt;
      byte_n   = byte_q;
      sel_n    = sel_q;
      hi_n     = hi_q;
      two_n    = two_q;
      long_n   = long_q;
      wr_ready = (state == W_IDLE);
      case (state)
         W_IDLE: begin
            if (wr_valid) begin
               state_n = W_SETUP;
               cnt_n   = SETUP_LD;
               byte_n  = wr_byte;
               sel_n   = wr_rs;
               hi_n    = (BUS_WIDTH == 4);
               two_n   = (BUS_WIDTH == 4) && !wr_nibble_only;
               long_n  = wr_long || (!wr_rs && !wr_nibble_only &&
                                     (wr_byte inside {8'h01, 8'h02, 8'h03}));
            end
         end
         W_SETUP: begin
            if (cnt == '0) begin
               state_n = W_PULSE;
               cnt_n   = E_LD;
            end else begin
               cnt_n = cnt - 1'b1;
            end
         end
         W_PULSE: begin
            if (cnt == '0) begin
               state_n = W_HOLD;
               cnt_n   = SETUP_LD;
            end else begin
               cnt_n = cnt - 1'b1;
            end
         end
         W_HOLD: begin
            if (cnt == '0) begin
               if (hi_q && two_q) begin
                  state_n = W_SETUP;
                  cnt_n   = SETUP_LD;
                  hi_n    = 1'b0;
               end else begin
                  state_n = W_DELAY;
                  cnt_n   = long_q ? CLEAR_LD : CMD_LD;
               end
            end else begin
               cnt_n = cnt - 1'b1;
            end
         end
         W_DELAY: begin
            if (cnt == '0) begin
               state_n = W_IDLE;
            end else begin
               cnt_n = cnt - 1'b1;
            end
         end
         default: state_n = W_IDLE;
      endcase
   end

   // Data presented on the pins for the upcoming phase: full byte or current nibble.
   always_comb begin
      db_n = '0;
      if (BUS_WIDTH == 8) begin
         db_n = BUS_WIDTH'(byte_n);
      end else begin
         db_n = BUS_WIDTH'(hi_n ? byte_n[7:4] : byte_n[3:0]);
      end
   end

   // Registered LCD pins so e/rs/db never glitch; bus is parked at zero between writes.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         e  <= 1'b0;
         rs <= 1'b0;
         db <= '0;
      end else begin
         e <= (state_n == W_PULSE);
         if (state_n inside {W_SETUP, W_PULSE, W_HOLD}) begin
            rs <= sel_n;
            db <= db_n;
         end else begin
            rs <= 1'b0;
            db <= '0;
         end
      end
   end

endmodule

// File: rtl/hd44780_ctrl.sv
// HD44780 controller top: power-on wait, init sequence, raw commands and
// full-screen refresh from a row-major character RAM.
module hd44780_ctrl
   import hd44780_pkg::*;
#(
   parameter int CLK_HZ     = 250_000,
   parameter int BUS_WIDTH  = 8,
   parameter int LINES      = 4,
   parameter int COLS       = 20,
   parameter int POWERON_US = 100_000,
   parameter int CMD_US     = 80,
   parameter int CLEAR_US   = 2_000,
   parameter int SETUP_CYC  = 1,
   parameter int E_CYC      = 2
) (
   input logic      clk,
   input logic      rst,
   hd44780_if.slave bus
);

   localparam int NCHARS = LINES * COLS;
   localparam int ADDR_W = (NCHARS > 1) ? $clog2(NCHARS) : 1;
   localparam int COL_W  = (COLS > 1) ? $clog2(COLS) : 1;
   localparam int PWR_N  = us2cyc(POWERON_US, CLK_HZ);
   localparam int PWR_W  = $clog2(PWR_N + 1);

   localparam logic [PWR_W-1:0] PWR_LAST  = PWR_W'(PWR_N - 1);
   localparam logic [COL_W-1:0] LAST_COL  = COL_W'(COLS - 1);
   localparam logic [1:0]       LAST_LINE = 2'(LINES - 1);
   localparam logic [7:0]       FSET      = fset_byte(BUS_WIDTH, LINES);

   ctrl_state_t       state, state_n;
   logic [PWR_W-1:0]  pwr_cnt, pwr_n;
   logic [3:0]        step, step_n;
   logic [1:0]        line_idx, line_n;
   logic [COL_W-1:0]  col_idx, col_n;
   logic [ADDR_W-1:0] addr_q, addr_n;
   logic [7:0]        cmd_q, cmd_n;
   logic              pend, pend_n;
   logic              done_q, done_n;
   logic              idle_free;

   logic              wr_valid, wr_ready, wr_rs, wr_nib, wr_long;
   logic [7:0]        wr_byte;

   hd44780_bus_writer #(
      .CLK_HZ    (CLK_HZ),
      .BUS_WIDTH (BUS_WIDTH),
      .CMD_US    (CMD_US),
      .CLEAR_US  (CLEAR_US),
      .SETUP_CYC (SETUP_CYC),
      .E_CYC     (E_CYC)
   ) u_writer (
      .clk            (clk),
      .rst            (rst),
      .wr_valid       (wr_valid),
      .wr_ready       (wr_ready),
      .wr_byte        (wr_byte),
      .wr_rs          (wr_rs),
      .wr_nibble_only (wr_nib),
      .wr_long        (wr_long),
      .e              (bus.e),
      .rs             (bus.rs),
      .db             (bus.db)
   );

   // The controller only counts as idle once the last write has finished on the LCD.
   assign idle_free     = (state == S_IDLE) && wr_ready;
   assign bus.cmd_ready = idle_free;
   assign bus.busy      = !idle_free;
   assign bus.init_done = done_q;
   assign bus.mem_addr  = addr_q;

   // Main FSM state plus counters, pending-refresh flag and latched command.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= S_PWR;
         pwr_cnt  <= '0;
         step     <= '0;
         line_idx <= '0;
         col_idx  <= '0;
         addr_q   <= '0;
         cmd_q    <= '0;
         pend     <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state    <= state_n;
         pwr_cnt  <= pwr_n;
         step     <= step_n;
         line_idx <= line_n;
         col_idx  <= col_n;
         addr_q   <= addr_n;
         cmd_q    <= cmd_n;
         pend     <= pend_n;
         done_q   <= done_n;
      end
   end

   // Next-state logic and the byte offered to the bus writer in each state.
   always_comb begin
      state_n  = state;
      pwr_n    = pwr_cnt;
      step_n   = step;
      line_n   = line_idx;
      col_n    = col_idx;
      addr_n   = addr_q;
      cmd_n    = cmd_q;
      pend_n   = pend || bus.trg;
      done_n   = done_q || idle_free;
      wr_valid = 1'b0;
      wr_byte  = 8'h00;
      wr_rs    = 1'b0;
      wr_nib   = 1'b0;
      wr_long  = 1'b0;
      case (state)
         S_PWR: begin
            if (pwr_cnt == PWR_LAST) begin
               state_n = S_INIT;
               step_n  = '0;
            end else begin
               pwr_n = pwr_cnt + 1'b1;
            end
         end
         S_INIT: begin
            wr_valid = 1'b1;
            wr_byte  = init_byte(step, FSET);
            wr_nib   = (step <= 4'd3);
            wr_long  = (step == 4'd0);
            if (wr_ready) begin
               if (step == 4'd8) begin
                  state_n = S_IDLE;
               end else if (step == 4'd2 && BUS_WIDTH == 8) begin
                  step_n = 4'd4;
               end else begin
                  step_n = step + 1'b1;
               end
            end
         end
         S_IDLE: begin
            if (wr_ready) begin
               if (bus.cmd_valid) begin
                  cmd_n   = bus.cmd_data;
                  state_n = S_CMD;
               end else if (pend || bus.trg) begin
                  pend_n  = 1'b0;
                  line_n  = '0;
                  state_n = S_ADDR;
               end
            end
         end
         S_CMD: begin
            wr_valid = 1'b1;
            wr_byte  = cmd_q;
            if (wr_ready) begin
               state_n = S_IDLE;
            end
         end
         S_ADDR: begin
            wr_valid = 1'b1;
            wr_byte  = OP_SET_DDRAM | line_base(line_idx, COLS);
            if (wr_ready) begin
               state_n = S_FETCH;
               col_n   = '0;
               addr_n  = (line_idx == 2'd0) ? '0 : addr_q + 1'b1;
            end
         end
         S_FETCH: begin
            state_n = S_CHAR;
         end
         S_CHAR: begin
            wr_valid = 1'b1;
            wr_byte  = bus.mem_data;
            wr_rs    = 1'b1;
            if (wr_ready) begin
               if (col_idx == LAST_COL) begin
                  if (line_idx == LAST_LINE) begin
                     state_n = S_IDLE;
                  end else begin
                     line_n  = line_idx + 1'b1;
                     state_n = S_ADDR;
                  end
               end else begin
                  col_n   = col_idx + 1'b1;
                  addr_n  = addr_q + 1'b1;
                  state_n = S_FETCH;
               end
            end
         end
         default: state_n = S_PWR;
      endcase
   end

endmodule

// File: tb/tb_hd44780_ctrl.sv
// Self-checking bench: an 8-bit 4x20 controller and a 4-bit 2x2 controller
// with directed vectors, plus sequences for refresh, command and reset corners.
module tb_hd44780_ctrl;

   typedef struct {
      logic [7:0] cmd;
      int         exp_gap;
      logic [8:0] exp_pulse;
   } cmd_vec_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   cyc = 0;
   int   tests_run = 0;
   int   tests_failed = 0;

   always #5 clk = ~clk;

   // Free-running cycle count used to time enable pulses.
   always @(posedge clk) cyc <= cyc + 1;

   hd44780_if #(.BUS_WIDTH(8), .ADDR_W(7)) if8 ();
   hd44780_if #(.BUS_WIDTH(4), .ADDR_W(2)) if4 ();

   hd44780_ctrl dut8 (
      .clk (clk),
      .rst (rst),
      .bus (if8.slave)
   );

   hd44780_ctrl #(
      .BUS_WIDTH  (4),
      .LINES      (2),
      .COLS       (2),
      .POWERON_US (1000)
   ) dut4 (
      .clk (clk),
      .rst (rst),
      .bus (if4.slave)
   );

   logic [7:0] ram8 [0:79];
   logic [7:0] ram4 [0:3];

   // Synchronous-read character RAMs.
   always @(posedge clk) begin
      if8.mem_data <= ram8[if8.mem_addr];
      if4.mem_data <= ram4[if4.mem_addr];
   end

   logic       e8_q = 1'b0;
   logic       e4_q = 1'b0;
   logic [8:0] pulses8 [$];
   int         rise8 [$];
   logic [4:0] pulses4 [$];

   // Record {rs, db} at every rising edge of e, sampled mid-cycle.
   always @(negedge clk) begin
      e8_q <= if8.e;
      e4_q <= if4.e;
      if (if8.e && !e8_q) begin
         pulses8.push_back({if8.rs, if8.db});
         rise8.push_back(cyc);
      end
      if (if4.e && !e4_q) begin
         pulses4.push_back({if4.rs, if4.db});
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, got, exp);
      end
   endtask

   function automatic logic [8:0] pulse8At(input int idx);
      return (idx < pulses8.size()) ? pulses8[idx] : 9'h1FF;
   endfunction

   function automatic logic [4:0] pulse4At(input int idx);
      return (idx < pulses4.size()) ? pulses4[idx] : 5'h1F;
   endfunction

   task automatic pulseTrg(input bit sel4);
      @(negedge clk);
      if (sel4) if4.trg = 1'b1; else if8.trg = 1'b1;
      @(negedge clk);
      if4.trg = 1'b0;
      if8.trg = 1'b0;
   endtask

   task automatic waitIdle(input bit sel4, input int maxc, output bit ok, output int at_cyc);
      ok = 1'b0;
      at_cyc = 0;
      for (int i = 0; i < maxc; i++) begin
         @(negedge clk);
         if (!(sel4 ? if4.busy : if8.busy)) begin
            ok = 1'b1;
            at_cyc = cyc;
            break;
         end
      end
   endtask

   // Present a raw command on the 8-bit controller and hold it until accepted.
   task automatic applyStimulus(input logic [7:0] c, input int maxc, output bit ok);
      ok = 1'b0;
      if8.cmd_valid = 1'b1;
      if8.cmd_data  = c;
      for (int i = 0; i < maxc; i++) begin
         if (if8.cmd_ready) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      @(posedge clk);
      #1;
      if8.cmd_valid = 1'b0;
   endtask

   logic [8:0] init8 [0:7];
   logic [4:0] init4 [0:13];
   logic [4:0] refr4 [0:11];
   logic [8:0] refr8 [0:83];
   cmd_vec_t   cmd_tab [0:4];

   initial begin
      bit ok;
      int at, base, t0;
      logic [7:0] lb [0:3];

      init8 = '{9'h030, 9'h030, 9'h030, 9'h038, 9'h008, 9'h001, 9'h006, 9'h00C};
      init4 = '{5'h03, 5'h03, 5'h03, 5'h02, 5'h02, 5'h08, 5'h00, 5'h08,
                5'h00, 5'h01, 5'h00, 5'h06, 5'h00, 5'h0C};
      refr4 = '{5'h08, 5'h00, 5'h14, 5'h11, 5'h14, 5'h12,
                5'h0C, 5'h00, 5'h14, 5'h13, 5'h14, 5'h14};
      lb = '{8'h80, 8'hC0, 8'h94, 8'hD4};
      for (int l = 0; l < 4; l++) begin
         refr8[l*21] = {1'b0, lb[l]};
         for (int c = 0; c < 20; c++) refr8[l*21 + 1 + c] = {1'b1, 8'(l*20 + c)};
      end
      cmd_tab[0] = '{8'h01, 503, 9'h001};
      cmd_tab[1] = '{8'h0C, 23, 9'h00C};
      cmd_tab[2] = '{8'h02, 503, 9'h002};
      cmd_tab[3] = '{8'h03, 503, 9'h003};
      cmd_tab[4] = '{8'h85, 23, 9'h085};

      for (int i = 0; i < 80; i++) ram8[i] = 8'(i);
      ram4 = '{8'h41, 8'h42, 8'h43, 8'h44};
      if8.trg = 1'b0; if8.cmd_valid = 1'b0; if8.cmd_data = 8'h00;
      if4.trg = 1'b0; if4.cmd_valid = 1'b0; if4.cmd_data = 8'h00;

      // Reset state
      repeat (3) @(negedge clk);
      checkOutput("rst_e", if8.e, 0);
      checkOutput("rst_rs", if8.rs, 0);
      checkOutput("rst_db", if8.db, 0);
      checkOutput("rst_mem_addr", if8.mem_addr, 0);
      checkOutput("rst_cmd_ready", if8.cmd_ready, 0);
      checkOutput("rst_init_done", if8.init_done, 0);
      checkOutput("rst_busy", if8.busy, 1);

      // Power-on wait and 8-bit init
      rst = 1'b1;
      t0 = cyc;
      repeat (25000) @(negedge clk);
      checkOutput("pwr_no_e", pulses8.size(), 0);
      checkOutput("pwr_busy", if8.busy, 1);
      ok = 1'b0;
      for (int i = 0; i < 5000; i++) begin
         @(negedge clk);
         if (if8.init_done) begin ok = 1'b1; break; end
      end
      checkOutput("init8_timeout", ok, 1);
      checkOutput("init8_count", pulses8.size(), 8);
      for (int i = 0; i < 8; i++) checkOutput($sformatf("init8_pulse%0d", i), pulse8At(i), init8[i]);
      checkOutput("init8_first_rise_late", (rise8.size() > 0 && rise8[0] - t0 >= 25000), 1);
      checkOutput("init8_clear_wait", (rise8.size() > 1 && rise8[1] - rise8[0] >= 503), 1);
      checkOutput("idle_busy", if8.busy, 0);
      checkOutput("idle_cmd_ready", if8.cmd_ready, 1);

      // 4-bit init nibbles
      checkOutput("init4_done", if4.init_done, 1);
      checkOutput("init4_count", pulses4.size(), 14);
      for (int i = 0; i < 14; i++) checkOutput($sformatf("init4_pulse%0d", i), pulse4At(i), init4[i]);

      // 4-bit refresh: each byte as high then low nibble
      base = pulses4.size();
      pulseTrg(1'b1);
      waitIdle(1'b1, 2000, ok, at);
      checkOutput("refr4_timeout", ok, 1);
      checkOutput("refr4_count", pulses4.size() - base, 12);
      for (int i = 0; i < 12; i++) checkOutput($sformatf("refr4_pulse%0d", i), pulse4At(base + i), refr4[i]);

      // 8-bit full refresh
      base = pulses8.size();
      pulseTrg(1'b0);
      checkOutput("trg_busy_next", if8.busy, 1);
      waitIdle(1'b0, 5000, ok, at);
      checkOutput("refr8_timeout", ok, 1);
      checkOutput("refr8_count", pulses8.size() - base, 84);
      for (int i = 0; i < 84; i++) checkOutput($sformatf("refr8_pulse%0d", i), pulse8At(base + i), refr8[i]);
      checkOutput("refr8_addr_hold", if8.mem_addr, 79);

      // Raw command vectors with their post-write wait
      for (int k = 0; k < 5; k++) begin
         base = pulses8.size();
         @(negedge clk);
         applyStimulus(cmd_tab[k].cmd, 100, ok);
         checkOutput($sformatf("cmd%0d_accept", k), ok, 1);
         waitIdle(1'b0, 2000, ok, at);
         checkOutput($sformatf("cmd%0d_timeout", k), ok, 1);
         checkOutput($sformatf("cmd%0d_count", k), pulses8.size() - base, 1);
         checkOutput($sformatf("cmd%0d_pulse", k), pulse8At(base), cmd_tab[k].exp_pulse);
         checkOutput($sformatf("cmd%0d_gap", k),
                     (rise8.size() > base) ? at - rise8[base] : -1, cmd_tab[k].exp_gap);
      end

      // Command held off during refresh, then executed after it
      base = pulses8.size();
      pulseTrg(1'b0);
      repeat (50) @(negedge clk);
      if8.cmd_valid = 1'b1;
      if8.cmd_data  = 8'h0C;
      @(negedge clk);
      checkOutput("held_cmd_ready", if8.cmd_ready, 0);
      applyStimulus(8'h0C, 5000, ok);
      checkOutput("held_accept", ok, 1);
      waitIdle(1'b0, 2000, ok, at);
      checkOutput("held_timeout", ok, 1);
      checkOutput("held_count", pulses8.size() - base, 85);
      checkOutput("held_last_char", pulse8At(base + 83), 9'h14F);
      checkOutput("held_cmd_pulse", pulse8At(base + 84), 9'h00C);

      // Three triggers during a refresh collapse to one extra refresh
      base = pulses8.size();
      pulseTrg(1'b0);
      repeat (100) @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         pulseTrg(1'b0);
         repeat (10) @(negedge clk);
      end
      repeat (6000) @(negedge clk);
      checkOutput("multi_trg_count", pulses8.size() - base, 168);
      checkOutput("multi_trg_busy", if8.busy, 0);
      checkOutput("multi_trg_second_addr", pulse8At(base + 84), 9'h080);

      // Reset in the middle of a character pulse
      pulseTrg(1'b0);
      repeat (200) @(negedge clk);
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         if (if8.e) begin ok = 1'b1; break; end
         @(negedge clk);
      end
      checkOutput("abort_found_e", ok, 1);
      rst = 1'b0;
      #1;
      checkOutput("abort_e", if8.e, 0);
      checkOutput("abort_db", if8.db, 0);
      checkOutput("abort_busy", if8.busy, 1);
      checkOutput("abort_init_done", if8.init_done, 0);
      checkOutput("abort_mem_addr", if8.mem_addr, 0);
      @(negedge clk);
      rst = 1'b1;
      base = pulses8.size();
      t0 = cyc;
      ok = 1'b0;
      for (int i = 0; i < 30000; i++) begin
         @(negedge clk);
         if (if8.init_done) begin ok = 1'b1; break; end
      end
      checkOutput("reinit_timeout", ok, 1);
      checkOutput("reinit_count", pulses8.size() - base, 8);
      checkOutput("reinit_first", pulse8At(base), 9'h030);
      checkOutput("reinit_last", pulse8At(base + 7), 9'h00C);
      checkOutput("reinit_pwr_wait", (rise8.size() > base && rise8[base] - t0 >= 25000), 1);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
